bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_bus_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : bus_responder
//  Purpose  : Asynchronous-strobe bus slave with a 16 x 32-bit register file
//             mapped into a 64-byte window. All bus inputs are brought into
//             the comm_clock domain through 2-flop synchronizers. The cycle
//             is acknowledged with DSACK1/DSACK0 (32-bit port) after a
//             programmable number of wait states.
//  Options  : BUS_RESPONDER_BERR_EN - when defined, misaligned accesses
//             (address[1:0] != 0) and writes to register 0 end with a bus
//             error instead of an acknowledge.
//  Ports    : comm_clock   - clock, rising edge
//             reset_n      - asynchronous active-low reset
//             bus_as_n     - address strobe (async, active low)
//             bus_ds_n     - data strobe (async, active low)
//             bus_rw       - 1 = read, 0 = write
//             bus_ad_in    - multiplexed address/data from the pins
//             bus_ad_out   - read data toward the pins
//             bus_ad_oe    - output enable for bus_ad_out
//             bus_data_dir - transceiver direction, 1 = FPGA to bus
//             bus_dsack_n  - DSACK1/DSACK0, active low
//             bus_berr_n   - bus error, active low
//  Revision : 1.0 - initial release
// ============================================================================
module bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFF00000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFFFFC0,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h46494447
) (
    input  logic        comm_clock,
    input  logic        reset_n,
    input  logic        bus_as_n,
    input  logic        bus_ds_n,
    input  logic        bus_rw,
    input  logic [31:0] bus_ad_in,
    output logic [31:0] bus_ad_out,
    output logic        bus_ad_oe,
    output logic        bus_data_dir,
    output logic [1:0]  bus_dsack_n,
    output logic        bus_berr_n
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_DECODE  = 3'd1;
    localparam logic [2:0] C_WAIT_DS = 3'd2;
    localparam logic [2:0] C_WAIT    = 3'd3;
    localparam logic [2:0] C_ACK     = 3'd4;
    localparam logic [2:0] C_RELEASE = 3'd5;
`ifdef BUS_RESPONDER_BERR_EN
    localparam logic [2:0] C_ERR     = 3'd6;
`endif

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    // ------------------------------------------------------------------------
    // Input synchronizers (reset to the idle/negated level)
    // ------------------------------------------------------------------------
    logic        as_n_meta_q, as_n_sync_q;
    logic        ds_n_meta_q, ds_n_sync_q;
    logic        rw_meta_q,   rw_sync_q;
    logic [31:0] ad_meta_q,   ad_sync_q;

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            as_n_meta_q <= 1'b1;
            as_n_sync_q <= 1'b1;
            ds_n_meta_q <= 1'b1;
            ds_n_sync_q <= 1'b1;
            rw_meta_q   <= 1'b1;
            rw_sync_q   <= 1'b1;
            ad_meta_q   <= '0;
            ad_sync_q   <= '0;
        end else begin
            as_n_meta_q <= bus_as_n;
            as_n_sync_q <= as_n_meta_q;
            ds_n_meta_q <= bus_ds_n;
            ds_n_sync_q <= ds_n_meta_q;
            rw_meta_q   <= bus_rw;
            rw_sync_q   <= rw_meta_q;
            ad_meta_q   <= bus_ad_in;
            ad_sync_q   <= ad_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Registered state and datapath
    // ------------------------------------------------------------------------
    logic [2:0]  state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic        rw_q,     rw_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic        armed_q,  armed_d;
    logic [1:0]  settle_q, settle_d;
    logic [31:0] regs_q [0:15];
    logic [31:0] regs_d [0:15];

    logic [3:0]  w_idx;
    logic        w_selected;
    logic        w_start;
    logic        w_bad_access;
    logic        w_wr_en;
    logic [31:0] w_rdata;

    assign w_idx      = addr_q[5:2];
    assign w_selected = ((addr_q & ADDR_MASK) == BASE_ADDR);

    // A cycle may only start once AS has been observed high by a settled
    // synchronizer; this rejects a cycle that was already running when reset
    // was released and enforces AS-high between consecutive cycles.
    assign w_start = (state_q == C_IDLE) && armed_q && !as_n_sync_q;

`ifdef BUS_RESPONDER_BERR_EN
    assign w_bad_access = (addr_q[1:0] != 2'b00) || (!rw_q && (w_idx == 4'd0));
`else
    assign w_bad_access = 1'b0;
`endif

    // Register 0 is the read-only ID word; its flop slot is never written.
    assign w_wr_en = (state_q == C_WAIT) && (state_d == C_ACK) &&
                     !rw_q && (w_idx != 4'd0);
    assign w_rdata = (w_idx == 4'd0) ? ID_VALUE : regs_q[w_idx];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: begin
                if (w_start) state_d = C_DECODE;
            end
            C_DECODE: begin
                state_d = w_selected ? C_WAIT_DS : C_RELEASE;
            end
            C_WAIT_DS: begin
                if (as_n_sync_q)       state_d = C_IDLE;
                else if (!ds_n_sync_q) state_d = C_WAIT;
            end
            C_WAIT: begin
                if (as_n_sync_q) begin
                    state_d = C_IDLE;
                end else if (cnt_q == 4'd0) begin
`ifdef BUS_RESPONDER_BERR_EN
                    state_d = w_bad_access ? C_ERR : C_ACK;
`else
                    state_d = C_ACK;
`endif
                end
            end
            C_ACK: begin
                if (as_n_sync_q) state_d = C_RELEASE;
            end
`ifdef BUS_RESPONDER_BERR_EN
            C_ERR: begin
                if (as_n_sync_q) state_d = C_RELEASE;
            end
`endif
            C_RELEASE: begin
                if (as_n_sync_q) state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (decoded from state so reset releases them immediately)
    // Data is driven only while WAIT/ACK of a read; RELEASE turns the
    // transceiver back around before the next cycle can start.
    // ------------------------------------------------------------------------
    always_comb begin
        bus_dsack_n  = 2'b11;
        bus_berr_n   = 1'b1;
        bus_ad_oe    = 1'b0;
        bus_data_dir = 1'b0;
        bus_ad_out   = '0;
        case (state_q)
            C_WAIT: begin
                if (rw_q) begin
                    bus_ad_oe    = 1'b1;
                    bus_data_dir = 1'b1;
                    bus_ad_out   = w_rdata;
                end
            end
            C_ACK: begin
                bus_dsack_n = 2'b00;
                if (rw_q) begin
                    bus_ad_oe    = 1'b1;
                    bus_data_dir = 1'b1;
                    bus_ad_out   = w_rdata;
                end
            end
`ifdef BUS_RESPONDER_BERR_EN
            C_ERR: begin
                bus_berr_n = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        regs_d   = regs_q;
        // Two cycles after reset the synchronizer holds real pin samples.
        settle_d = {settle_q[0], 1'b1};

        if (w_start) begin
            addr_d  = ad_sync_q;
            armed_d = 1'b0;
        end else if (settle_q[1] && as_n_sync_q) begin
            armed_d = 1'b1;
        end

        if ((state_q == C_WAIT_DS) && !as_n_sync_q && !ds_n_sync_q) begin
            rw_d    = rw_sync_q;
            wdata_d = ad_sync_q;
            cnt_d   = C_WAIT_LOAD;
        end else if ((state_q == C_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (w_wr_en && !w_bad_access) begin
            regs_d[w_idx] = wdata_q;
        end
    end

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            rw_q     <= 1'b1;
            wdata_q  <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            settle_q <= 2'b00;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
            regs_q   <= regs_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_responder
//  Purpose  : Randomized scoreboard bench for bus_responder. The stimulus
//             process issues complete bus cycles and queues the response a
//             simple register-array model predicts; an independent monitor
//             pops and compares each time DSACK or BERR asserts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

    localparam logic [31:0] BASE = 32'hFFF00000;
    localparam logic [31:0] MASK = 32'hFFFFFFC0;
    localparam logic [31:0] ID   = 32'h46494447;
    localparam int          WS   = 3;
    // DS driven just after edge n: two synchronizer edges, the FSM samples it
    // at edge n+3, then WS+1 cycles of waiting -> DSACK after edge n+3+WS+1.
    localparam int          LAT  = 3 + WS + 1;
`ifdef BUS_RESPONDER_BERR_EN
    localparam bit          BERR = 1'b1;
`else
    localparam bit          BERR = 1'b0;
`endif

    logic        comm_clock = 1'b0;
    logic        reset_n    = 1'b0;
    logic        bus_as_n   = 1'b1;
    logic        bus_ds_n   = 1'b1;
    logic        bus_rw     = 1'b1;
    logic [31:0] bus_ad_in  = '0;
    logic [31:0] bus_ad_out;
    logic        bus_ad_oe;
    logic        bus_data_dir;
    logic [1:0]  bus_dsack_n;
    logic        bus_berr_n;

    bus_responder #(
        .BASE_ADDR   (BASE),
        .ADDR_MASK   (MASK),
        .WAIT_STATES (WS),
        .ID_VALUE    (ID)
    ) dut (
        .comm_clock   (comm_clock),
        .reset_n      (reset_n),
        .bus_as_n     (bus_as_n),
        .bus_ds_n     (bus_ds_n),
        .bus_rw       (bus_rw),
        .bus_ad_in    (bus_ad_in),
        .bus_ad_out   (bus_ad_out),
        .bus_ad_oe    (bus_ad_oe),
        .bus_data_dir (bus_data_dir),
        .bus_dsack_n  (bus_dsack_n),
        .bus_berr_n   (bus_berr_n)
    );

    always #5 comm_clock = ~comm_clock;

    typedef struct {
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
        int          ds_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:15];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          quiet = 1'b0;
    bit          prev_resp = 1'b0;

    always @(posedge comm_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit sel(input logic [31:0] a);
        return (a & MASK) == BASE;
    endfunction

    function automatic bit err_access(input logic [31:0] a, input logic rw);
        return BERR && ((a[1:0] != 2'b00) || (!rw && (a[5:2] == 4'd0)));
    endfunction

    function automatic bit resp_now();
        return (bus_dsack_n == 2'b00) || (bus_berr_n == 1'b0);
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    always @(negedge comm_clock) begin : mon
        exp_t e;
        bit   r;
        r = resp_now();
        if (r && !prev_resp) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {bus_dsack_n, bus_berr_n}, 3'b111);
            end else begin
                e = sb.pop_front();
                check("resp_kind", {bus_dsack_n, bus_berr_n}, e.is_err ? 3'b110 : 3'b001);
                check("resp_latency", cyc - e.ds_cyc, LAT);
                if (!e.is_err) begin
                    check("oe_dir", {bus_ad_oe, bus_data_dir}, e.is_read ? 2'b11 : 2'b00);
                    if (e.is_read) check("read_data", bus_ad_out, e.data);
                end
            end
        end
        if (quiet) check("quiet", {bus_dsack_n, bus_berr_n, bus_ad_oe}, 4'b1110);
        prev_resp = r;
    end

    // ------------------------------------------------------------------------
    // One complete bus cycle
    // ------------------------------------------------------------------------
    task automatic bus_cycle(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                             input bit abort_it, input bit rst_in_ack);
        exp_t e;
        bit   s;
        bit   got;
        int   idx;
        s   = sel(addr);
        idx = int'(addr[5:2]);
        @(posedge comm_clock); #1;
        bus_ad_in = addr;
        bus_rw    = rw;
        @(posedge comm_clock); #1;
        bus_as_n = 1'b0;
        quiet    = !s;
        repeat (5) @(posedge comm_clock);
        #1;
        bus_ad_in = rw ? $urandom : wdata;
        @(posedge comm_clock); #1;
        if (s && !abort_it) begin
            e.is_err  = err_access(addr, rw);
            e.is_read = rw;
            e.data    = (idx == 0) ? ID : model[idx];
            e.ds_cyc  = cyc;
            if (!e.is_err && !rw && idx != 0) model[idx] = wdata;
            sb.push_back(e);
        end
        bus_ds_n = 1'b0;
        if (abort_it) begin
            @(posedge comm_clock); #1;
            bus_as_n = 1'b1;
            bus_ds_n = 1'b1;
            repeat (12) @(posedge comm_clock);
        end else if (!s) begin
            repeat (15) @(posedge comm_clock);
            #1;
            bus_as_n = 1'b1;
            bus_ds_n = 1'b1;
            repeat (4) @(posedge comm_clock);
            quiet = 1'b0;
        end else begin
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge comm_clock);
                if (resp_now()) got = 1'b1;
            end
            check("resp_timeout", got, 1'b1);
            if (rst_in_ack) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("rst_dsack", bus_dsack_n, 2'b11);
                check("rst_berr", bus_berr_n, 1'b1);
                check("rst_oe", bus_ad_oe, 1'b0);
                check("rst_dir", bus_data_dir, 1'b0);
                check("rst_ad_out", bus_ad_out, 32'h0);
                for (int i = 0; i < 16; i++) model[i] = '0;
                // Keep a selecting address and both strobes low: the cycle
                // in progress must be ignored after reset is released.
                bus_ad_in = addr;
                @(posedge comm_clock);
                @(posedge comm_clock); #1;
                reset_n = 1'b1;
                quiet   = 1'b1;
                repeat (20) @(posedge comm_clock);
                #1;
                bus_as_n = 1'b1;
                bus_ds_n = 1'b1;
                repeat (4) @(posedge comm_clock);
                quiet = 1'b0;
            end else begin
                @(posedge comm_clock); #1;
                bus_as_n = 1'b1;
                bus_ds_n = 1'b1;
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(negedge comm_clock);
                    if (bus_dsack_n == 2'b11 && bus_berr_n == 1'b1) got = 1'b1;
                end
                check("release_timeout", got, 1'b1);
                repeat (3) @(posedge comm_clock);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stim
        logic [31:0] a;
        logic        rw;
        bit          ab;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (3) @(posedge comm_clock);
        #1;
        check("reset_dsack", bus_dsack_n, 2'b11);
        check("reset_berr", bus_berr_n, 1'b1);
        check("reset_oe", bus_ad_oe, 1'b0);
        check("reset_dir", bus_data_dir, 1'b0);
        check("reset_ad_out", bus_ad_out, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge comm_clock);

        bus_cycle(BASE + 32'h04, 1'b0, 32'h12345678, 1'b0, 1'b0);
        bus_cycle(BASE + 32'h04, 1'b1, 32'h0,        1'b0, 1'b0);
        bus_cycle(BASE,          1'b1, 32'h0,        1'b0, 1'b0);
        bus_cycle(BASE,          1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        bus_cycle(BASE,          1'b1, 32'h0,        1'b0, 1'b0);
        bus_cycle(32'h00001000,  1'b1, 32'h0,        1'b0, 1'b0);
        bus_cycle(BASE + 32'h08, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        bus_cycle(BASE + 32'h08, 1'b1, 32'h0,        1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rw = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 7) == 0);
            bus_cycle(a, rw, $urandom, ab, 1'b0);
        end

        bus_cycle(BASE + 32'h0C, 1'b0, 32'hA5A5F00D, 1'b0, 1'b0);
        bus_cycle(BASE + 32'h0C, 1'b1, 32'h0,        1'b0, 1'b1);
        bus_cycle(BASE + 32'h0C, 1'b1, 32'h0,        1'b0, 1'b0);
        bus_cycle(BASE,          1'b1, 32'h0,        1'b0, 1'b0);

        repeat (5) @(posedge comm_clock);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
